// File: rtl/axi_pwm_master.sv
// AXI4-Lite initiator driving the PWM control slave: single write, single read, duty broadcast.
// Optional per-phase watchdog enabled by defining AXI_PWM_MASTER_TIMEOUT_EN.
module axi_pwm_master #(
    parameter int unsigned C_NUM_PWM = 2,
    parameter int unsigned C_TIMEOUT = 255
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_OP,
    input  logic [8:0]  CMD_ADDR,
    input  logic [31:0] CMD_DATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_DATA,
    output logic        RSP_ERR,
    output logic        RSP_TIMEOUT,
    output logic [8:0]  M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [8:0]  M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_RESP} state_t;

    localparam logic [5:0] LP_LAST_IDX   = 6'(C_NUM_PWM - 1);
    localparam logic [8:0] LP_BCAST_BASE = 9'h100;

    if ((C_NUM_PWM < 1) || (C_NUM_PWM > 64)) begin : g_bad_num_pwm
        $error("axi_pwm_master: C_NUM_PWM must be 1..64");
    end
    if ((C_TIMEOUT < 1) || (C_TIMEOUT > 65535)) begin : g_bad_timeout
        $error("axi_pwm_master: C_TIMEOUT must be 1..65535");
    end

    state_t      r_state,     w_nxt_state;
    logic        r_bcast,     w_nxt_bcast;
    logic [5:0]  r_idx,       w_nxt_idx;
    logic        r_err,       w_nxt_err;
    logic [8:0]  r_awaddr,    w_nxt_awaddr;
    logic [31:0] r_wdata,     w_nxt_wdata;
    logic [8:0]  r_araddr,    w_nxt_araddr;
    logic        r_awvalid,   w_nxt_awvalid;
    logic        r_wvalid,    w_nxt_wvalid;
    logic        r_bready,    w_nxt_bready;
    logic        r_arvalid,   w_nxt_arvalid;
    logic        r_rready,    w_nxt_rready;
    logic        r_cmd_ready, w_nxt_cmd_ready;
    logic        r_rsp_valid, w_nxt_rsp_valid;
    logic [31:0] r_rsp_data,  w_nxt_rsp_data;
    logic        r_rsp_err,   w_nxt_rsp_err;
    logic        r_rsp_tmo,   w_nxt_rsp_tmo;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_any_hs;
    logic w_err_acc;
    logic w_wait_tmo;

    assign w_aw_hs   = r_awvalid & M_AXI_AWREADY;
    assign w_w_hs    = r_wvalid & M_AXI_WREADY;
    assign w_b_hs    = r_bready & M_AXI_BVALID;
    assign w_ar_hs   = r_arvalid & M_AXI_ARREADY;
    assign w_r_hs    = r_rready & M_AXI_RVALID;
    assign w_any_hs  = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;
    assign w_err_acc = r_err | (M_AXI_BRESP != 2'b00);

`ifdef AXI_PWM_MASTER_TIMEOUT_EN
    localparam logic [15:0] LP_TMO_LAST = 16'(C_TIMEOUT - 1);

    logic [15:0] r_tcnt;
    logic        w_waiting;

    assign w_waiting  = (r_state == ST_WRITE) || (r_state == ST_READ);
    assign w_wait_tmo = w_waiting && !w_any_hs && (r_tcnt == LP_TMO_LAST);

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET || (w_nxt_state != r_state) || w_any_hs) begin
            r_tcnt <= '0;
        end else if (w_waiting) begin
            r_tcnt <= r_tcnt + 16'd1;
        end
    end
`else
    assign w_wait_tmo = 1'b0;
`endif

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_bcast     = r_bcast;
        w_nxt_idx       = r_idx;
        w_nxt_err       = r_err;
        w_nxt_awaddr    = r_awaddr;
        w_nxt_wdata     = r_wdata;
        w_nxt_araddr    = r_araddr;
        w_nxt_awvalid   = r_awvalid;
        w_nxt_wvalid    = r_wvalid;
        w_nxt_bready    = r_bready;
        w_nxt_arvalid   = r_arvalid;
        w_nxt_rready    = r_rready;
        w_nxt_cmd_ready = r_cmd_ready;
        w_nxt_rsp_valid = 1'b0;
        w_nxt_rsp_data  = '0;
        w_nxt_rsp_err   = 1'b0;
        w_nxt_rsp_tmo   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_nxt_cmd_ready = 1'b1;
                if (CMD_VALID && r_cmd_ready) begin
                    w_nxt_cmd_ready = 1'b0;
                    w_nxt_idx       = '0;
                    w_nxt_err       = 1'b0;
                    // Opcode bit 0 selects read, which also covers the reserved 2'b11.
                    if (CMD_OP[0]) begin
                        w_nxt_state   = ST_READ;
                        w_nxt_araddr  = CMD_ADDR;
                        w_nxt_arvalid = 1'b1;
                        w_nxt_rready  = 1'b1;
                    end else begin
                        w_nxt_state   = ST_WRITE;
                        w_nxt_bcast   = CMD_OP[1];
                        w_nxt_awaddr  = CMD_OP[1] ? LP_BCAST_BASE : CMD_ADDR;
                        w_nxt_wdata   = CMD_DATA;
                        w_nxt_awvalid = 1'b1;
                        w_nxt_wvalid  = 1'b1;
                        w_nxt_bready  = 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                if (w_aw_hs) w_nxt_awvalid = 1'b0;
                if (w_w_hs)  w_nxt_wvalid  = 1'b0;
                // B closes the channel even if it beats AW/W; broadcast then re-arms both.
                if (w_b_hs) begin
                    w_nxt_err = w_err_acc;
                    if (r_bcast && (r_idx != LP_LAST_IDX)) begin
                        w_nxt_idx     = r_idx + 6'd1;
                        w_nxt_awaddr  = r_awaddr + 9'd1;
                        w_nxt_awvalid = 1'b1;
                        w_nxt_wvalid  = 1'b1;
                    end else begin
                        w_nxt_awvalid   = 1'b0;
                        w_nxt_wvalid    = 1'b0;
                        w_nxt_bready    = 1'b0;
                        w_nxt_state     = ST_RESP;
                        w_nxt_rsp_valid = 1'b1;
                        w_nxt_rsp_err   = w_err_acc;
                    end
                end else if (w_wait_tmo) begin
                    w_nxt_awvalid   = 1'b0;
                    w_nxt_wvalid    = 1'b0;
                    w_nxt_bready    = 1'b0;
                    w_nxt_state     = ST_RESP;
                    w_nxt_rsp_valid = 1'b1;
                    w_nxt_rsp_err   = 1'b1;
                    w_nxt_rsp_tmo   = 1'b1;
                end
            end

            ST_READ: begin
                if (w_ar_hs) w_nxt_arvalid = 1'b0;
                if (w_r_hs) begin
                    w_nxt_arvalid   = 1'b0;
                    w_nxt_rready    = 1'b0;
                    w_nxt_state     = ST_RESP;
                    w_nxt_rsp_valid = 1'b1;
                    w_nxt_rsp_data  = M_AXI_RDATA;
                    w_nxt_rsp_err   = (M_AXI_RRESP != 2'b00);
                end else if (w_wait_tmo) begin
                    w_nxt_arvalid   = 1'b0;
                    w_nxt_rready    = 1'b0;
                    w_nxt_state     = ST_RESP;
                    w_nxt_rsp_valid = 1'b1;
                    w_nxt_rsp_err   = 1'b1;
                    w_nxt_rsp_tmo   = 1'b1;
                end
            end

            ST_RESP: begin
                w_nxt_state     = ST_IDLE;
                w_nxt_cmd_ready = 1'b1;
            end

            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_state     <= ST_IDLE;
            r_bcast     <= 1'b0;
            r_idx       <= '0;
            r_err       <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_araddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_tmo   <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_bcast     <= w_nxt_bcast;
            r_idx       <= w_nxt_idx;
            r_err       <= w_nxt_err;
            r_awaddr    <= w_nxt_awaddr;
            r_wdata     <= w_nxt_wdata;
            r_araddr    <= w_nxt_araddr;
            r_awvalid   <= w_nxt_awvalid;
            r_wvalid    <= w_nxt_wvalid;
            r_bready    <= w_nxt_bready;
            r_arvalid   <= w_nxt_arvalid;
            r_rready    <= w_nxt_rready;
            r_cmd_ready <= w_nxt_cmd_ready;
            r_rsp_valid <= w_nxt_rsp_valid;
            r_rsp_data  <= w_nxt_rsp_data;
            r_rsp_err   <= w_nxt_rsp_err;
            r_rsp_tmo   <= w_nxt_rsp_tmo;
        end
    end

    assign CMD_READY     = r_cmd_ready;
    assign RSP_VALID     = r_rsp_valid;
    assign RSP_DATA      = r_rsp_data;
    assign RSP_ERR       = r_rsp_err;
    assign RSP_TIMEOUT   = r_rsp_tmo;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_pwm_master.sv
// Directed bench for axi_pwm_master with a one-cycle-ready slave model and a manual slave mode.
// Builds with or without AXI_PWM_MASTER_TIMEOUT_EN.
module tb_axi_pwm_master;

    localparam int unsigned NPWM = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        CMD_VALID, CMD_READY;
    logic [1:0]  CMD_OP;
    logic [8:0]  CMD_ADDR;
    logic [31:0] CMD_DATA;
    logic        RSP_VALID, RSP_ERR, RSP_TIMEOUT;
    logic [31:0] RSP_DATA;
    logic [8:0]  M_AXI_AWADDR, M_AXI_ARADDR;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    axi_pwm_master #(.C_NUM_PWM(NPWM), .C_TIMEOUT(8)) u_dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
        .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    // Slave model: READY and B/R responses registered one cycle after VALID.
    logic        s_awready = 1'b0, s_wready = 1'b0, s_bvalid = 1'b0, s_rvalid = 1'b0;
    logic [1:0]  s_bresp = 2'b00;
    logic        manual = 1'b0, m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
    logic [31:0] rd_data = '0;
    logic [1:0]  rd_resp = 2'b00;
    int          wr_cnt = 0;
    int          err_idx = -1;
    logic [8:0]  log_addr [0:63];
    logic [31:0] log_data [0:63];

    always @(posedge clk) begin
        s_awready <= M_AXI_AWVALID && !s_awready;
        s_wready  <= M_AXI_WVALID && !s_wready;
        s_bvalid  <= M_AXI_AWVALID && M_AXI_WVALID && !s_awready;
        s_bresp   <= (wr_cnt == err_idx) ? 2'b10 : 2'b00;
        s_rvalid  <= M_AXI_ARVALID && M_AXI_ARREADY && !s_rvalid;
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            log_addr[wr_cnt[5:0]] <= M_AXI_AWADDR;
            log_data[wr_cnt[5:0]] <= M_AXI_WDATA;
            wr_cnt <= wr_cnt + 1;
        end
    end

    assign M_AXI_AWREADY = manual ? m_awready : s_awready;
    assign M_AXI_WREADY  = manual ? m_wready  : s_wready;
    assign M_AXI_BVALID  = manual ? m_bvalid  : s_bvalid;
    assign M_AXI_BRESP   = manual ? 2'b00     : s_bresp;
    assign M_AXI_ARREADY = 1'b1;
    assign M_AXI_RVALID  = s_rvalid;
    assign M_AXI_RDATA   = rd_data;
    assign M_AXI_RRESP   = rd_resp;

    int rsp_cnt = 0, overlap = 0, tmo_cnt = 0;
    always @(negedge clk) begin
        if (RSP_VALID) rsp_cnt = rsp_cnt + 1;
        if (RSP_VALID && CMD_READY) overlap = overlap + 1;
        if (RSP_TIMEOUT) tmo_cnt = tmo_cnt + 1;
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for one edge; returns in cycle 1 of the transaction.
    task automatic issue(input logic [1:0] op, input logic [8:0] addr, input logic [31:0] data);
        chk("cmd_ready_pre", 32'(CMD_READY), 32'd1);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_ADDR  = addr;
        CMD_DATA  = data;
        tick();
        CMD_VALID = 1'b0;
    endtask

    int base, rbase;

    initial begin
        CMD_VALID = 1'b0;
        CMD_OP    = 2'b00;
        CMD_ADDR  = '0;
        CMD_DATA  = '0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_cmd_ready", 32'(CMD_READY), 32'd0);
        chk("rst_awvalid",   32'(M_AXI_AWVALID), 32'd0);
        chk("rst_wvalid",    32'(M_AXI_WVALID), 32'd0);
        chk("rst_bready",    32'(M_AXI_BREADY), 32'd0);
        chk("rst_arvalid",   32'(M_AXI_ARVALID), 32'd0);
        chk("rst_rready",    32'(M_AXI_RREADY), 32'd0);
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("rst_awaddr",    32'(M_AXI_AWADDR), 32'd0);
        chk("rst_wdata",     M_AXI_WDATA, 32'd0);
        rst = 1'b0;
        tick();
        chk("cmd_ready_after_rst", 32'(CMD_READY), 32'd1);

        // Single write
        base = wr_cnt;
        issue(2'b00, 9'h004, 32'h3);
        chk("wr_awvalid_c1", 32'(M_AXI_AWVALID), 32'd1);
        chk("wr_wvalid_c1",  32'(M_AXI_WVALID), 32'd1);
        chk("wr_awaddr_c1",  32'(M_AXI_AWADDR), 32'h004);
        chk("wr_wdata_c1",   M_AXI_WDATA, 32'h3);
        chk("wr_wstrb_c1",   32'(M_AXI_WSTRB), 32'hF);
        chk("wr_bready_c1",  32'(M_AXI_BREADY), 32'd1);
        tick();
        chk("wr_rsp_c2", 32'(RSP_VALID), 32'd0);
        tick();
        chk("wr_rsp_c3",      32'(RSP_VALID), 32'd1);
        chk("wr_rsp_err_c3",  32'(RSP_ERR), 32'd0);
        chk("wr_rsp_data_c3", RSP_DATA, 32'd0);
        chk("wr_cmdrdy_c3",   32'(CMD_READY), 32'd0);
        tick();
        chk("wr_rsp_c4",    32'(RSP_VALID), 32'd0);
        chk("wr_cmdrdy_c4", 32'(CMD_READY), 32'd1);
        chk("wr_count",     32'(wr_cnt - base), 32'd1);

        // Read OKAY
        rd_data = 32'h3;
        rd_resp = 2'b00;
        issue(2'b01, 9'h004, 32'h0);
        chk("rd_arvalid_c1", 32'(M_AXI_ARVALID), 32'd1);
        chk("rd_araddr_c1",  32'(M_AXI_ARADDR), 32'h004);
        chk("rd_awvalid_c1", 32'(M_AXI_AWVALID), 32'd0);
        tick();
        chk("rd_arvalid_c2", 32'(M_AXI_ARVALID), 32'd0);
        tick();
        chk("rd_rsp_c3",      32'(RSP_VALID), 32'd1);
        chk("rd_rsp_data_c3", RSP_DATA, 32'h3);
        chk("rd_rsp_err_c3",  32'(RSP_ERR), 32'd0);
        tick();

        // Read SLVERR
        rd_data = 32'hDEAD_BEEF;
        rd_resp = 2'b10;
        issue(2'b01, 9'h00C, 32'h0);
        chk("rderr_araddr", 32'(M_AXI_ARADDR), 32'h00C);
        tick();
        tick();
        chk("rderr_rsp",  32'(RSP_VALID), 32'd1);
        chk("rderr_err",  32'(RSP_ERR), 32'd1);
        chk("rderr_data", RSP_DATA, 32'hDEAD_BEEF);
        tick();

        // Reserved opcode behaves as read
        rd_data = 32'h55;
        rd_resp = 2'b00;
        issue(2'b11, 9'h010, 32'hFFFF_FFFF);
        chk("op11_arvalid", 32'(M_AXI_ARVALID), 32'd1);
        chk("op11_awvalid", 32'(M_AXI_AWVALID), 32'd0);
        tick();
        tick();
        chk("op11_rsp",  32'(RSP_VALID), 32'd1);
        chk("op11_data", RSP_DATA, 32'h55);
        tick();

        // Broadcast, all OKAY
        base = wr_cnt;
        issue(2'b10, 9'h1FF, 32'h0000_8000);
        chk("bc_awaddr_c1", 32'(M_AXI_AWADDR), 32'h100);
        repeat (9) tick();
        chk("bc_rsp_c10", 32'(RSP_VALID), 32'd0);
        tick();
        chk("bc_rsp_c11",  32'(RSP_VALID), 32'd1);
        chk("bc_err_c11",  32'(RSP_ERR), 32'd0);
        chk("bc_data_c11", RSP_DATA, 32'd0);
        chk("bc_count",    32'(wr_cnt - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("bc_addr", 32'(log_addr[(base + i) % 64]), 32'h100 + 32'(i));
            chk("bc_wdata", log_data[(base + i) % 64], 32'h0000_8000);
        end
        tick();

        // Broadcast with SLVERR on the third write
        base = wr_cnt;
        err_idx = base + 2;
        issue(2'b10, 9'h000, 32'h0000_8000);
        repeat (10) tick();
        chk("bcerr_rsp",   32'(RSP_VALID), 32'd1);
        chk("bcerr_err",   32'(RSP_ERR), 32'd1);
        chk("bcerr_count", 32'(wr_cnt - base), 32'd5);
        chk("bcerr_last_addr", 32'(log_addr[(base + 4) % 64]), 32'h104);
        err_idx = -1;
        tick();

        // Independent AW/W/B timing from a manual slave
        manual = 1'b1;
        rbase = rsp_cnt;
        issue(2'b00, 9'h008, 32'h77);
        m_awready = 1'b1;
        tick();
        m_awready = 1'b0;
        chk("man_awvalid_c2", 32'(M_AXI_AWVALID), 32'd0);
        chk("man_wvalid_c2",  32'(M_AXI_WVALID), 32'd1);
        tick();
        chk("man_wvalid_c3", 32'(M_AXI_WVALID), 32'd1);
        tick();
        m_wready = 1'b1;
        tick();
        m_wready = 1'b0;
        m_bvalid = 1'b1;
        chk("man_wvalid_c5", 32'(M_AXI_WVALID), 32'd0);
        chk("man_bready_c5", 32'(M_AXI_BREADY), 32'd1);
        chk("man_rsp_c5",    32'(RSP_VALID), 32'd0);
        tick();
        m_bvalid = 1'b0;
        chk("man_rsp_c6", 32'(RSP_VALID), 32'd1);
        chk("man_err_c6", 32'(RSP_ERR), 32'd0);
        tick();
        tick();
        chk("man_rsp_count", 32'(rsp_cnt - rbase), 32'd1);
        manual = 1'b0;
        tick();

        // Reset in the middle of a broadcast
        rbase = rsp_cnt;
        issue(2'b10, 9'h000, 32'h1234);
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_awvalid", 32'(M_AXI_AWVALID), 32'd0);
        chk("mrst_wvalid",  32'(M_AXI_WVALID), 32'd0);
        chk("mrst_bready",  32'(M_AXI_BREADY), 32'd0);
        chk("mrst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
        chk("mrst_rsp",     32'(RSP_VALID), 32'd0);
        chk("mrst_cmdrdy",  32'(CMD_READY), 32'd0);
        rst = 1'b0;
        tick();
        chk("mrst_cmdrdy_after", 32'(CMD_READY), 32'd1);
        repeat (12) tick();
        chk("mrst_no_rsp", 32'(rsp_cnt - rbase), 32'd0);

        // Slave that never accepts AW/W
        manual = 1'b1;
        rbase = rsp_cnt;
        issue(2'b00, 9'h020, 32'hA5);
`ifdef AXI_PWM_MASTER_TIMEOUT_EN
        repeat (7) tick();
        chk("tmo_rsp_c8",     32'(RSP_VALID), 32'd0);
        chk("tmo_awvalid_c8", 32'(M_AXI_AWVALID), 32'd1);
        tick();
        chk("tmo_rsp_c9",     32'(RSP_VALID), 32'd1);
        chk("tmo_err_c9",     32'(RSP_ERR), 32'd1);
        chk("tmo_flag_c9",    32'(RSP_TIMEOUT), 32'd1);
        chk("tmo_awvalid_c9", 32'(M_AXI_AWVALID), 32'd0);
        chk("tmo_wvalid_c9",  32'(M_AXI_WVALID), 32'd0);
        chk("tmo_bready_c9",  32'(M_AXI_BREADY), 32'd0);
        tick();
        chk("tmo_cmdrdy", 32'(CMD_READY), 32'd1);
        manual = 1'b0;
        tick();
        chk("tmo_count", 32'(tmo_cnt), 32'd1);
`else
        repeat (1000) tick();
        chk("hang_awvalid", 32'(M_AXI_AWVALID), 32'd1);
        chk("hang_wvalid",  32'(M_AXI_WVALID), 32'd1);
        chk("hang_bready",  32'(M_AXI_BREADY), 32'd1);
        chk("hang_no_rsp",  32'(rsp_cnt - rbase), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        manual = 1'b0;
        chk("hang_recover_cmdrdy", 32'(CMD_READY), 32'd1);
        chk("no_timeout_flag", 32'(tmo_cnt), 32'd0);
`endif

        chk("rsp_cmd_overlap", 32'(overlap), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_pwm_master.md
# axi_pwm_master

AXI4-Lite initiator that drives the PWM core's control slave from a simple command port. It lets local fabric logic (a sequencer, a soft controller) do single register writes and reads on the PWM slave, plus a broadcast that loads one duty value into every PWM channel. It sits between fabric control logic and the PWM core's `S_AXI_*` port, on the same AXI clock.

## Interface
- `C_NUM_PWM`, 2: number of PWM channels targeted by broadcast, 1–64.
- `C_TIMEOUT`, 255: per-phase wait limit in cycles, 1–65535. Used only when `AXI_PWM_MASTER_TIMEOUT_EN` is defined.

- `M_AXI_ACLK` in 1: the single clock.
- `M_AXI_ARESET` in 1: synchronous, active-high reset.
- `CMD_VALID` in 1: command request.
- `CMD_READY` out 1: command accepted on `CMD_VALID && CMD_READY`.
- `CMD_OP` in 2: command opcode.
  - 00: write.
  - 01: read.
  - 10: broadcast.
  - 11: reserved; executes as a read.
- `CMD_ADDR` in 9: byte address for write and read; ignored for broadcast.
- `CMD_DATA` in 32: write or broadcast data.
- `RSP_VALID` out 1: one-cycle completion pulse; there is no backpressure.
- `RSP_DATA` out 32: read data; 0 for write and broadcast.
- `RSP_ERR` out 1: any non-OKAY response, or a timeout.
- `RSP_TIMEOUT` out 1: a timeout caused the abort.
- `M_AXI_AWADDR` out 9; `M_AXI_AWVALID` out 1; `M_AXI_AWREADY` in 1.
- `M_AXI_WDATA` out 32; `M_AXI_WSTRB` out 4, constant 4'hF; `M_AXI_WVALID` out 1; `M_AXI_WREADY` in 1.
- `M_AXI_BRESP` in 2; `M_AXI_BVALID` in 1; `M_AXI_BREADY` out 1.
- `M_AXI_ARADDR` out 9; `M_AXI_ARVALID` out 1; `M_AXI_ARREADY` in 1.
- `M_AXI_RDATA` in 32; `M_AXI_RRESP` in 2; `M_AXI_RVALID` in 1; `M_AXI_RREADY` out 1.

## Operation
- **FSM states:** IDLE, WRITE, READ, RESP.
- **IDLE:** `CMD_READY`=1. On accept, latch op/addr/data, clear index and error, then go to:
  - WRITE for write and broadcast.
  - READ for read.
- **WRITE:**
  - `AWVALID` and `WVALID` assert together.
  - Each one drops independently the cycle after its own READY handshake.
  - `BREADY`=1 for the whole state.
  - B is taken on `BVALID`, including when `BVALID` arrives in the same cycle as the AW/W handshakes, or before either of them.
  - On B, OR `(BRESP!=0)` into the error flag.
- **Broadcast addressing:**
  - Target address is 9'h100 + index; `WDATA`=`CMD_DATA`.
  - After each B: if index == `C_NUM_PWM`-1, go to RESP. Otherwise increment index and re-issue AW/W in the next cycle, back in WRITE.
  - For write, AWADDR = `CMD_ADDR`; go to RESP after B.
- **READ:**
  - `ARVALID` holds until `ARREADY`; `RREADY`=1 for the whole state.
  - On `RVALID`, capture `RDATA`, set error from `RRESP!=0`, then go to RESP.
  - `RVALID` in the same cycle as `ARREADY` is accepted.
- **RESP:** drive `RSP_VALID`=1 for one cycle with `RSP_DATA`/`RSP_ERR`/`RSP_TIMEOUT`, then return to IDLE.
- **Reset values:**
  - `CMD_READY`=0 during reset, 1 the cycle after.
  - All VALID/READY outputs are 0.
  - `RSP_*`=0, addresses/data=0.
- **Reset mid-transaction:** the FSM returns to IDLE on the next edge, all AXI valids drop, and no response is issued.

## Timing
- Command to AXI valid: one cycle. Command accepted at cycle 0 → `AWVALID`/`WVALID`/`ARVALID` high at cycle 1.
- Against a slave that registers READY and BVALID/RVALID one cycle after VALID:
  - Write: handshake and B at cycle 2; `RSP_VALID` at cycle 3.
  - Read: AR handshake at cycle 1 (`ARREADY` idle-high); R at cycle 2; `RSP_VALID` at cycle 3.
  - Broadcast: two cycles per channel; `RSP_VALID` at cycle 2·`C_NUM_PWM`+1.
- AXI outputs are registered with no combinational ready→valid path.
- `RSP_VALID` and `CMD_READY` are never both high in the same cycle.
- Back-to-back: a new command can be accepted one cycle after `RSP_VALID`.

## Configuration
- **`AXI_PWM_MASTER_TIMEOUT_EN` defined:**
  - A 16-bit counter clears on every state entry and on every handshake, and increments while waiting.
  - Reaching `C_TIMEOUT` drops all valids and READYs, sets `RSP_ERR`=1 and `RSP_TIMEOUT`=1, and goes to RESP. A broadcast stops at the current index.
  - This is a recovery path that knowingly violates AXI VALID stability.
- **Macro undefined:** there is no counter, waits are unbounded, and `RSP_TIMEOUT` is tied to 0.

## Test plan
- Write op=00, addr 9'h004, data 32'h3 against a one-cycle-ready slave model:
  - AW/W observed at cycle 1 with WSTRB F.
  - `RSP_VALID` at cycle 3 with ERR=0, DATA=0.
- Read op=01, addr 9'h004, slave returns 32'h3:
  - `RSP_DATA`=32'h3 at cycle 3.
  - Read of 9'h00C with RRESP=2'b10 → `RSP_ERR`=1.
- Broadcast, `C_NUM_PWM`=5, data 32'h00_8000:
  - Five writes at addresses 100–104, each WDATA 8000.
  - One `RSP_VALID` at cycle 11.
  - BRESP=SLVERR on the third write → `RSP_ERR`=1 and all five writes still issued.
- Slave gives AWREADY at cycle 1, WREADY at cycle 4, BVALID at cycle 5:
  - `AWVALID` low from cycle 2; `WVALID` low from cycle 5.
  - Exactly one response, at cycle 6.
- Reset asserted at cycle 2 of a broadcast:
  - All valids are 0 at cycle 3, with no `RSP_VALID`.
  - `CMD_READY`=1 one cycle after reset deasserts.
- With macro, `C_TIMEOUT`=8, slave never asserts AWREADY:
  - `RSP_VALID` with ERR=1 and TIMEOUT=1 after 8 waiting cycles.
  - Without the macro, the DUT is still in WRITE after 1000 cycles.
